// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS datapath: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, gates state-changing enables, traps on faults.
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWr,
  input  logic             MemWr,
  input  logic             MemtoReg,
  input  logic             Branch,
  input  logic             Jump,
  input  logic             JumpReg,
  input  logic             JrWr,
  input  logic             OverflowCheck,
  input  logic             ConfirmBr,
  input  logic             OF,
  input  logic             DmError,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             IRWr,
  output logic             PCInc,
  output logic             PCBr,
  output logic             RegWrEn,
  output logic             MemWrEn,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  localparam logic [3:0] WMAX = 4'(WAIT_MAX);

  state_t     st, nxt;
  logic [3:0] wait_cnt;
  logic       wait_inc;
  logic       retire;
  logic [1:0] new_cause;
  logic       mem_first;

  assign state     = st;
  // wait_cnt is cleared on entry to MEM, so zero marks the first MEM cycle
  assign mem_first = (wait_cnt == '0);

  always_comb begin
    nxt       = st;
    wait_inc  = 1'b0;
    retire    = 1'b0;
    new_cause = 2'd0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    IRWr      = 1'b0;
    PCInc     = 1'b0;
    PCBr      = 1'b0;
    RegWrEn   = 1'b0;
    MemWrEn   = 1'b0;
    case (st)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWr  = 1'b1;
          PCInc = 1'b1;
          nxt   = DECODE;
        end else if (wait_cnt == WMAX) begin
          nxt       = TRAP;
          new_cause = 2'd3;
        end else begin
          wait_inc = 1'b1;
        end
      end
      DECODE: nxt = EXEC;
      EXEC: begin
        if (OverflowCheck && OF) begin
          nxt       = TRAP;
          new_cause = 2'd1;
        end else if (Jump || JumpReg || (Branch && ConfirmBr)) begin
          PCBr = 1'b1;
          if (JrWr) begin
            nxt = WB;
          end else begin
            nxt    = FETCH;
            retire = 1'b1;
          end
        end else if (Branch) begin
          nxt    = FETCH;
          retire = 1'b1;
        end else if (MemWr || MemtoReg) begin
          nxt = MEM;
        end else if (RegWr) begin
          nxt = WB;
        end else begin
          nxt    = FETCH;
          retire = 1'b1;
        end
      end
      MEM: begin
        if (mem_first && DmError) begin
          nxt       = TRAP;
          new_cause = 2'd2;
        end else begin
          dmem_req = 1'b1;
          MemWrEn  = MemWr;
          if (dmem_ready) begin
            if (MemWr) begin
              nxt    = FETCH;
              retire = 1'b1;
            end else begin
              nxt = WB;
            end
          end else if (wait_cnt == WMAX) begin
            nxt       = TRAP;
            new_cause = 2'd3;
          end else begin
            wait_inc = 1'b1;
          end
        end
      end
      WB: begin
        RegWrEn = 1'b1;
        nxt     = FETCH;
        retire  = 1'b1;
      end
      default: nxt = TRAP;
    endcase
    // Outputs are decoded from state, so they must also be forced low while
    // reset is held, otherwise FETCH would present imem_req during reset.
    if (!reset) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      IRWr     = 1'b0;
      PCInc    = 1'b0;
      PCBr     = 1'b0;
      RegWrEn  = 1'b0;
      MemWrEn  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= FETCH;
      wait_cnt    <= '0;
      trap        <= 1'b0;
      trap_cause  <= 2'd0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      st <= nxt;
      if (nxt != st)
        wait_cnt <= '0;
      else if (wait_inc)
        wait_cnt <= wait_cnt + 4'd1;
      if (st != TRAP)
        cycle_cnt <= cycle_cnt + 1'b1;
      if (retire)
        instret_cnt <= instret_cnt + 1'b1;
      if (nxt == TRAP && st != TRAP) begin
        trap       <= 1'b1;
        trap_cause <= new_cause;
      end
    end
  end

endmodule
